// File: rtl/ysyx_23060184_lsu.sv
// Memory-stage unit: takes one EXU result, performs at most one load/store over a
// request/response handshake, and hands the result to writeback.
module ysyx_23060184_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Evalid,
  output logic                  Mready,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] RD2,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            MemOp,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  Mvalid,
  input  logic                  Wready,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic                  Fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_valid_q, req_valid_d;
  logic                    mvalid_q, mvalid_d;
  logic                    fault_q, fault_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   alu_q, alu_d;
  logic [2:0]              memop_q, memop_d;

  logic                    is_mem_s;
  logic                    illegal_s;
  logic                    misalign_s;
  logic [1:0]              off_s;

  // Select and extend the addressed byte/half of a returned read word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  op);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (op)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b010:  res_v = word;
      3'b100:  res_v = {24'd0, byte_v};
      3'b101:  res_v = {16'd0, half_v};
      default: res_v = 32'd0;
    endcase
    return res_v;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] off, input logic [2:0] op);
    logic [3:0] m_v;
    case (op[1:0])
      2'b00:   m_v = 4'b0001 << off;
      2'b01:   m_v = 4'b0011 << off;
      default: m_v = 4'b1111;
    endcase
    return m_v;
  endfunction

  assign off_s      = ALUResult[1:0];
  assign is_mem_s   = MemRead | MemWrite;
  assign misalign_s = ((MemOp[1:0] == 2'b01) && off_s[0]) ||
                      ((MemOp[1:0] == 2'b10) && (off_s != 2'b00));
  assign illegal_s  = (MemRead && MemWrite) ||
                      (MemOp == 3'b011) || (MemOp == 3'b110) || (MemOp == 3'b111) ||
                      (MemWrite && MemOp[2]);

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      mvalid_q    <= 1'b0;
      fault_q     <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= 4'd0;
      rdata_q     <= '0;
      alu_q       <= '0;
      memop_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      mvalid_q    <= mvalid_d;
      fault_q     <= fault_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      alu_q       <= alu_d;
      memop_q     <= memop_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    mvalid_d    = mvalid_q;
    fault_d     = fault_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rdata_d     = rdata_q;
    alu_d       = alu_q;
    memop_d     = memop_q;
    case (state_q)
      S_IDLE: begin
        if (Evalid) begin
          alu_d   = ALUResult;
          memop_d = MemOp;
          rdata_d = '0;
          fault_d = 1'b0;
          if (!is_mem_s) begin
            state_d  = S_DONE;
            mvalid_d = 1'b1;
          end else if (illegal_s || misalign_s) begin
            // Faulting accesses never reach memory.
            state_d  = S_DONE;
            mvalid_d = 1'b1;
            fault_d  = 1'b1;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            addr_d      = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
            wen_d       = MemWrite;
            wdata_d     = RD2 << {off_s, 3'b000};
            wmask_d     = MemWrite ? store_mask(off_s, MemOp) : 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d  = S_DONE;
          mvalid_d = 1'b1;
          if (!wen_q) begin
            rdata_d = load_extend(mem_rdata, alu_q[1:0], memop_q);
          end else begin
            rdata_d = '0;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (Wready) begin
          state_d  = S_IDLE;
          mvalid_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_valid_d = 1'b0;
        mvalid_d    = 1'b0;
      end
    endcase
  end

  assign Mready        = (state_q == S_IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign Mvalid        = mvalid_q;
  assign ReadData      = rdata_q;
  assign ALUResultM    = alu_q;
  assign Fault         = fault_q;

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Self-checking bench for ysyx_23060184_lsu: directed operations, a spec-level
// reference model and a per-cycle compare process.
module tb_ysyx_23060184_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        Evalid, Mready;
  logic [31:0] ALUResult, RD2;
  logic        MemRead, MemWrite;
  logic [2:0]  MemOp;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        Mvalid, Wready;
  logic [31:0] ReadData, ALUResultM;
  logic        Fault;

  int checks = 0;
  int errors = 0;

  // expected protocol phase for the current cycle
  logic exp_idle = 1'b0, exp_req = 1'b0, exp_done = 1'b0, checking = 1'b0;
  // expected transaction contents
  logic        exp_has_req, exp_wen, exp_fault;
  logic [31:0] exp_addr, exp_wdata, exp_rd, exp_alu;
  logic [3:0]  exp_wmask;
  // DUT values observed during the last operation
  logic [31:0] obs_addr, obs_wdata, obs_rd, obs_alu;
  logic [3:0]  obs_wmask;
  logic        obs_wen, obs_fault;

  ysyx_23060184_lsu dut (
    .clk(clk), .rst(rst), .Evalid(Evalid), .Mready(Mready),
    .ALUResult(ALUResult), .RD2(RD2), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemOp(MemOp), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .Mvalid(Mvalid), .Wready(Wready), .ReadData(ReadData),
    .ALUResultM(ALUResultM), .Fault(Fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: derive the expected transaction from the operation's meaning.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic r,
                       input logic w, input logic [2:0] op, input logic [31:0] rdata);
    int          n, off;
    logic [63:0] v, lim;
    off = int'(a[1:0]);
    n   = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    exp_alu = a; exp_rd = 32'd0; exp_fault = 1'b0; exp_has_req = 1'b0;
    exp_wen = w; exp_addr = a - 32'(off); exp_wdata = 32'd0; exp_wmask = 4'd0;
    if (r || w) begin
      if ((r && w) || op == 3'b011 || op == 3'b110 || op == 3'b111 ||
          (w && op[2]) || (off % n != 0)) begin
        exp_fault = 1'b1;
      end else begin
        exp_has_req = 1'b1;
        v = {32'd0, d} << (8 * off);
        exp_wdata = v[31:0];
        exp_wmask = 4'((32'd1 << n) - 32'd1) << off;
        if (r) begin
          lim = 64'd1 << (8 * n);
          v = ({32'd0, rdata} >> (8 * off)) % lim;
          if (!op[2] && v >= (lim >> 1)) v = v - lim;
          exp_rd = v[31:0];
        end
      end
    end
  endtask

  // Per-cycle comparison of DUT outputs with the expected phase and contents.
  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("Mready", {31'd0, Mready}, {31'd0, exp_idle});
      chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, exp_req});
      chk("Mvalid", {31'd0, Mvalid}, {31'd0, exp_done});
      if (exp_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, exp_wen});
        if (exp_wen) begin
          chk("mem_wdata", mem_wdata, exp_wdata);
          chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
        end
      end
      if (exp_done) begin
        chk("ReadData", ReadData, exp_rd);
        chk("ALUResultM", ALUResultM, exp_alu);
        chk("Fault", {31'd0, Fault}, {31'd0, exp_fault});
      end
    end
  end

  task automatic scramble_inputs();
    Evalid = 1'b0; ALUResult = 32'hDEADBEEF; RD2 = 32'h5555AAAA;
    MemRead = 1'b0; MemWrite = 1'b0; MemOp = 3'b111;
  endtask

  // Drive one operation; called and returning at posedge+1 with the DUT idle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic r,
                       input logic w, input logic [2:0] op, input logic [31:0] rdata,
                       input int req_stall, input int wb_stall);
    model(a, d, r, w, op, rdata);
    ALUResult = a; RD2 = d; MemRead = r; MemWrite = w; MemOp = op; Evalid = 1'b1;
    @(posedge clk); #1;
    scramble_inputs();
    exp_idle = 1'b0;
    obs_addr = 32'd0; obs_wdata = 32'd0; obs_wmask = 4'd0; obs_wen = 1'b0;
    if (exp_has_req) begin
      exp_req = 1'b1;
      for (int k = 0; k <= req_stall; k++) begin
        mem_req_ready = (k == req_stall);
        if (k == 0) begin
          #3;
          obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wmask = mem_wmask; obs_wen = mem_wen;
        end
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0;
      exp_req = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rdata = 32'h0BAD0BAD;
    end
    exp_done = 1'b1;
    for (int k = 0; k <= wb_stall; k++) begin
      Wready = (k == wb_stall);
      if (k == wb_stall) begin
        #3;
        obs_rd = ReadData; obs_alu = ALUResultM; obs_fault = Fault;
      end
      @(posedge clk); #1;
    end
    Wready = 1'b0;
    exp_done = 1'b0;
    exp_idle = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    scramble_inputs();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0; Wready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst Mvalid", {31'd0, Mvalid}, 32'd0);
    chk("rst mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst ReadData", ReadData, 32'd0);
    chk("rst ALUResultM", ALUResultM, 32'd0);
    chk("rst Fault", {31'd0, Fault}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("rst Mready", {31'd0, Mready}, 32'd1);
    rst = 1'b0; exp_idle = 1'b1; checking = 1'b1;
    @(posedge clk); #1;

    // pass-through
    do_op(32'h00001234, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 0, 0);
    chk("pass ALUResultM", obs_alu, 32'h00001234);
    chk("pass ReadData", obs_rd, 32'h0);
    // lb / lbu at byte 3
    do_op(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b000, 32'h80FF0000, 0, 0);
    chk("lb addr", obs_addr, 32'h80000000);
    chk("lb data", obs_rd, 32'hFFFFFF80);
    do_op(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b100, 32'h80FF0000, 0, 0);
    chk("lbu data", obs_rd, 32'h00000080);
    // sh at offset 2
    do_op(32'h80000002, 32'hABCD1234, 1'b0, 1'b1, 3'b001, 32'h0, 0, 0);
    chk("sh wen", {31'd0, obs_wen}, 32'd1);
    chk("sh wmask", {28'd0, obs_wmask}, 32'h0000000C);
    chk("sh wdata", obs_wdata, 32'h12340000);
    chk("sh ReadData", obs_rd, 32'h0);
    // faults
    do_op(32'h80000001, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 0, 0);
    chk("lw misaligned fault", {31'd0, obs_fault}, 32'd1);
    do_op(32'h80000000, 32'h0, 1'b1, 1'b0, 3'b011, 32'h0, 0, 0);
    chk("memop 011 fault", {31'd0, obs_fault}, 32'd1);
    do_op(32'h80000000, 32'h11, 1'b0, 1'b1, 3'b100, 32'h0, 0, 0);
    chk("sbu fault", {31'd0, obs_fault}, 32'd1);
    do_op(32'h80000000, 32'h11, 1'b1, 1'b1, 3'b010, 32'h0, 0, 0);
    chk("read+write fault", {31'd0, obs_fault}, 32'd1);
    do_op(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b101, 32'h0, 0, 0);
    // half loads at offset 2, byte store at offset 1, word store, positive lb
    do_op(32'h80000102, 32'h0, 1'b1, 1'b0, 3'b001, 32'h80017FFF, 0, 0);
    chk("lh data", obs_rd, 32'hFFFF8001);
    do_op(32'h80000102, 32'h0, 1'b1, 1'b0, 3'b101, 32'h80017FFF, 0, 1);
    chk("lhu data", obs_rd, 32'h00008001);
    do_op(32'h80000201, 32'h000000A5, 1'b0, 1'b1, 3'b000, 32'h0, 1, 0);
    chk("sb wdata", obs_wdata, 32'h0000A500);
    chk("sb wmask", {28'd0, obs_wmask}, 32'h00000002);
    do_op(32'h80000300, 32'hCAFEBABE, 1'b0, 1'b1, 3'b010, 32'h0, 0, 0);
    do_op(32'h80000000, 32'h0, 1'b1, 1'b0, 3'b000, 32'h0000007F, 0, 0);
    chk("lb positive", obs_rd, 32'h0000007F);
    // back-pressure on both handshakes
    do_op(32'h80000008, 32'h0, 1'b1, 1'b0, 3'b010, 32'hCAFEF00D, 3, 2);
    chk("stalled lw data", obs_rd, 32'hCAFEF00D);

    // reset while waiting for a response
    model(32'h80000010, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0);
    ALUResult = 32'h80000010; MemRead = 1'b1; MemOp = 3'b010; Evalid = 1'b1;
    @(posedge clk); #1;
    scramble_inputs();
    exp_idle = 1'b0; exp_req = 1'b1; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; exp_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid-rst Mvalid", {31'd0, Mvalid}, 32'd0);
    chk("mid-rst Mready", {31'd0, Mready}, 32'd1);
    chk("mid-rst mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    exp_idle = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    do_op(32'h80000004, 32'h0, 1'b1, 1'b0, 3'b010, 32'h13579BDF, 0, 0);
    chk("post-rst lw data", obs_rd, 32'h13579BDF);
    chk("post-rst lw addr", obs_addr, 32'h80000004);

    @(posedge clk); #1;
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
